// File: rtl/rx_mac.sv
// ---------------------------------------------------------------------------
// rx_mac : receive-side Ethernet MAC.
//
// Takes the received byte (GMII/RGMII) or nibble (MII) stream, strips the
// preamble/SFD, holds the last four bytes back so the FCS is never forwarded,
// checks the FCS with a CRC-32 helper and forwards dst addr .. payload/pad as
// an AXI-Stream frame into the RX FIFO. tuser on the tlast beat flags a bad
// frame.
//
// Ports
//   clk, reset_n          core clock, synchronous active-low reset
//   rgmii_mac_rx_data     received byte (MII mode: nibble in [3:0])
//   rgmii_mac_rx_dv/er    frame envelope / PHY receive error
//   rgmii_mac_rx_rdy      sample strobe; the block only advances when it is 1
//   mii_select            1 = nibble (MII) mode, 0 = byte mode
//   m_rx_axis_*           frame stream out (no backpressure)
//   stat_frame_good/bad   one pulse per good / bad-or-aborted frame
// ---------------------------------------------------------------------------
module rx_mac #(
  parameter int DATA_WIDTH    = 8,
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] rgmii_mac_rx_data,
  input  logic                  rgmii_mac_rx_dv,
  input  logic                  rgmii_mac_rx_er,
  input  logic                  rgmii_mac_rx_rdy,
  output logic [DATA_WIDTH-1:0] m_rx_axis_tdata,
  output logic                  m_rx_axis_tvalid,
  output logic                  m_rx_axis_tlast,
  output logic                  m_rx_axis_tuser,
  input  logic                  mii_select,
  output logic                  stat_frame_good,
  output logic                  stat_frame_bad
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    PAYLOAD  = 2'd2,
    DROP     = 2'd3
  } state_t;

  localparam logic [7:0]  PRE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE = 8'hD5;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] MAX_LEN  = 11'(MAX_FRAME_LEN);
  localparam logic [10:0] OVR_LEN  = 11'(MAX_FRAME_LEN + 1);
  localparam logic [10:0] LEN_SAT  = 11'h7FF;
  localparam logic [10:0] FILL_LEN = 11'd4;

  // Reflected Ethernet CRC-32 (poly 0x04C11DB7), one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ 32'hEDB8_8320;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  state_t      state_r,     state_next_s;
  logic        nib_phase_r, nib_phase_next_s;
  logic [3:0]  nib_low_r,   nib_low_next_s;
  logic [3:0][7:0] dl_r,    dl_next_s;      // dl_r[0] is the oldest byte
  logic [31:0] crc_r,       crc_next_s;
  logic [10:0] len_r,       len_next_s;
  logic        err_r,       err_next_s;
  logic [7:0]  pend_r,      pend_next_s;
  logic        pend_v_r,    pend_v_next_s;
  logic [7:0]  tdata_r,     tdata_next_s;
  logic        tvalid_r,    tvalid_next_s;
  logic        tlast_r,     tlast_next_s;
  logic        tuser_r,     tuser_next_s;
  logic        good_r,      good_next_s;
  logic        bad_r,       bad_next_s;

  logic        byte_v_s;
  logic [7:0]  byte_s;
  logic        odd_s;
  logic        fcs_bad_s;
  logic        frame_bad_s;

  assign m_rx_axis_tdata  = tdata_r;
  assign m_rx_axis_tvalid = tvalid_r;
  assign m_rx_axis_tlast  = tlast_r;
  assign m_rx_axis_tuser  = tuser_r;
  assign stat_frame_good  = good_r;
  assign stat_frame_bad   = bad_r;

  // At end of frame the delay line holds the FCS with the first FCS byte in
  // dl_r[0], which lines up with the low byte of the complemented CRC.
  assign fcs_bad_s   = (~crc_r) != dl_r;
  assign frame_bad_s = fcs_bad_s | err_r | odd_s | (len_r < MIN_LEN) | (len_r > MAX_LEN);

  // Byte assembly: pairs nibbles in MII mode (low first), passes bytes otherwise.
  always_comb begin
    byte_v_s         = 1'b0;
    byte_s           = rgmii_mac_rx_data[7:0];
    odd_s            = 1'b0;
    nib_phase_next_s = nib_phase_r;
    nib_low_next_s   = nib_low_r;
    if (rgmii_mac_rx_rdy) begin
      if (rgmii_mac_rx_dv) begin
        if (mii_select) begin
          if (nib_phase_r) begin
            byte_v_s         = 1'b1;
            byte_s           = {rgmii_mac_rx_data[3:0], nib_low_r};
            nib_phase_next_s = 1'b0;
          end else begin
            nib_low_next_s   = rgmii_mac_rx_data[3:0];
            nib_phase_next_s = 1'b1;
          end
        end else begin
          byte_v_s         = 1'b1;
          nib_phase_next_s = 1'b0;
        end
      end else begin
        // dv falling with half a byte collected means an odd nibble count.
        odd_s            = nib_phase_r;
        nib_phase_next_s = 1'b0;
      end
    end else begin
      nib_phase_next_s = nib_phase_r;
    end
  end

  // Next-state and datapath logic; output strobes are single-cycle pulses.
  always_comb begin
    state_next_s  = state_r;
    dl_next_s     = dl_r;
    crc_next_s    = crc_r;
    len_next_s    = len_r;
    err_next_s    = err_r;
    pend_next_s   = pend_r;
    pend_v_next_s = pend_v_r;
    tdata_next_s  = tdata_r;
    tvalid_next_s = 1'b0;
    tlast_next_s  = 1'b0;
    tuser_next_s  = 1'b0;
    good_next_s   = 1'b0;
    bad_next_s    = 1'b0;

    case (state_r)
      IDLE: begin
        if (byte_v_s) begin
          if (byte_s == PRE_BYTE) begin
            state_next_s = PREAMBLE;
          end else begin
            state_next_s = DROP;
          end
        end else begin
          state_next_s = IDLE;
        end
      end

      PREAMBLE: begin
        if (rgmii_mac_rx_rdy && !rgmii_mac_rx_dv) begin
          state_next_s = IDLE;
        end else if (byte_v_s) begin
          if (byte_s == PRE_BYTE) begin
            state_next_s = PREAMBLE;
          end else if (byte_s == SFD_BYTE) begin
            state_next_s  = PAYLOAD;
            crc_next_s    = CRC_INIT;
            len_next_s    = 11'd0;
            err_next_s    = 1'b0;
            pend_v_next_s = 1'b0;
          end else begin
            state_next_s = DROP;
          end
        end else begin
          state_next_s = PREAMBLE;
        end
      end

      PAYLOAD: begin
        err_next_s = err_r | (rgmii_mac_rx_rdy & rgmii_mac_rx_dv & rgmii_mac_rx_er);
        if (rgmii_mac_rx_rdy && !rgmii_mac_rx_dv) begin
          // End of frame: flush the pending byte as tlast, or report a runt
          // that never got a byte past the FCS hold-back.
          state_next_s  = IDLE;
          pend_v_next_s = 1'b0;
          if (pend_v_r) begin
            tdata_next_s  = pend_r;
            tvalid_next_s = 1'b1;
            tlast_next_s  = 1'b1;
            tuser_next_s  = frame_bad_s;
            good_next_s   = ~frame_bad_s;
            bad_next_s    = frame_bad_s;
          end else begin
            bad_next_s = 1'b1;
          end
        end else if (rgmii_mac_rx_rdy && (len_r == OVR_LEN)) begin
          // Oversize: close the frame as bad and discard the rest of it.
          state_next_s  = DROP;
          pend_v_next_s = 1'b0;
          tdata_next_s  = pend_r;
          tvalid_next_s = pend_v_r;
          tlast_next_s  = pend_v_r;
          tuser_next_s  = pend_v_r;
          bad_next_s    = 1'b1;
        end else if (byte_v_s) begin
          state_next_s = PAYLOAD;
          len_next_s   = (len_r == LEN_SAT) ? len_r : (len_r + 11'd1);
          dl_next_s    = {byte_s, dl_r[3], dl_r[2], dl_r[1]};
          if (len_r >= FILL_LEN) begin
            crc_next_s    = crc32_byte(crc_r, dl_r[0]);
            pend_next_s   = dl_r[0];
            pend_v_next_s = 1'b1;
            tdata_next_s  = pend_r;
            tvalid_next_s = pend_v_r;
          end else begin
            pend_v_next_s = pend_v_r;
          end
        end else begin
          state_next_s = PAYLOAD;
        end
      end

      DROP: begin
        if (rgmii_mac_rx_rdy && !rgmii_mac_rx_dv) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DROP;
        end
      end

      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      nib_phase_r <= 1'b0;
      nib_low_r   <= 4'h0;
      dl_r        <= 32'h0000_0000;
      crc_r       <= CRC_INIT;
      len_r       <= 11'd0;
      err_r       <= 1'b0;
      pend_r      <= 8'h00;
      pend_v_r    <= 1'b0;
      tdata_r     <= 8'h00;
      tvalid_r    <= 1'b0;
      tlast_r     <= 1'b0;
      tuser_r     <= 1'b0;
      good_r      <= 1'b0;
      bad_r       <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      nib_phase_r <= nib_phase_next_s;
      nib_low_r   <= nib_low_next_s;
      dl_r        <= dl_next_s;
      crc_r       <= crc_next_s;
      len_r       <= len_next_s;
      err_r       <= err_next_s;
      pend_r      <= pend_next_s;
      pend_v_r    <= pend_v_next_s;
      tdata_r     <= tdata_next_s;
      tvalid_r    <= tvalid_next_s;
      tlast_r     <= tlast_next_s;
      tuser_r     <= tuser_next_s;
      good_r      <= good_next_s;
      bad_r       <= bad_next_s;
    end
  end

endmodule
